reg_file_sequencer: RTL and testbench

//   Command sequencer that sits directly upstream of the 8-entry register file and owns its rf_* port.

---
 rtl/reg_file_sequencer_if.sv | 20 ++
 rtl/reg_file_sequencer.sv | 114 +++++++++++
 tb/tb_reg_file_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sequencer_if.sv
// reg_file_sequencer_if: command and response handshakes of the register-file sequencer.
interface reg_file_sequencer_if #(parameter int N = 32);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [2:0]   cmd_src;
    logic [2:0]   cmd_dst;
    logic [N-1:0] cmd_imm;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer: expands LOAD/READ/MOVE/SWAP commands into exclusive register-file read/write cycles.
module reg_file_sequencer #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_sequencer_if.slave  bus,
    output logic                 rf_read_enable_o,
    output logic                 rf_write_enable_o,
    output logic [2:0]           rf_read_addr_o,
    output logic [2:0]           rf_write_addr_o,
    output logic [N-1:0]         rf_write_data_o,
    input  logic [N-1:0]         rf_read_data_i
);
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_READ = 2'd1;
    localparam logic [1:0] OP_MOVE = 2'd2;
    localparam logic [1:0] OP_SWAP = 2'd3;

    typedef enum logic [2:0] {IDLE, RD_A, CAP_A, RD_B, CAP_B, WR_A, WR_B, RESP} state_t;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [2:0]   src_q, src_d;
    logic [2:0]   dst_q, dst_d;
    logic [N-1:0] imm_q, imm_d;
    logic [N-1:0] temp_a_q, temp_a_d;
    logic [N-1:0] temp_b_q, temp_b_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            temp_a_q <= '0;
            temp_b_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            imm_q    <= imm_d;
            temp_a_q <= temp_a_d;
            temp_b_q <= temp_b_d;
        end
    end

    // cmd_ready is gated by rst_n so it drops asynchronously with reset.
    assign bus.cmd_ready = rst_n && (state_q == IDLE);

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        src_d             = src_q;
        dst_d             = dst_q;
        imm_d             = imm_q;
        temp_a_d          = temp_a_q;
        temp_b_d          = temp_b_q;
        rf_read_enable_o  = 1'b0;
        rf_write_enable_o = 1'b0;
        rf_read_addr_o    = '0;
        rf_write_addr_o   = '0;
        rf_write_data_o   = '0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_data      = '0;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                op_d    = bus.cmd_op;
                src_d   = bus.cmd_src;
                dst_d   = bus.cmd_dst;
                imm_d   = bus.cmd_imm;
                state_d = (bus.cmd_op == OP_LOAD) ? WR_A : RD_A;
            end
            RD_A: begin
                rf_read_enable_o = 1'b1;
                rf_read_addr_o   = src_q;
                state_d          = CAP_A;
            end
            CAP_A: begin
                temp_a_d = rf_read_data_i;
                state_d  = (op_q == OP_READ) ? RESP : (op_q == OP_MOVE) ? WR_A : RD_B;
            end
            RD_B: begin
                rf_read_enable_o = 1'b1;
                rf_read_addr_o   = dst_q;
                state_d          = CAP_B;
            end
            CAP_B: begin
                temp_b_d = rf_read_data_i;
                state_d  = WR_A;
            end
            WR_A: begin
                rf_write_enable_o = 1'b1;
                rf_write_addr_o   = dst_q;
                rf_write_data_o   = (op_q == OP_LOAD) ? imm_q : temp_a_q;
                state_d           = (op_q == OP_SWAP) ? WR_B : RESP;
            end
            WR_B: begin
                rf_write_enable_o = 1'b1;
                rf_write_addr_o   = src_q;
                rf_write_data_o   = temp_b_q;
                state_d           = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = (op_q == OP_LOAD) ? imm_q : temp_a_q;
                state_d       = bus.rsp_ready ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_reg_file_sequencer.sv
// tb_reg_file_sequencer: directed commands against a bench register file and a command-level model.
module tb_reg_file_sequencer;
    localparam int N = 32;
    localparam logic [1:0] LOAD = 2'd0, READ = 2'd1, MOVE = 2'd2, SWAP = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_sequencer_if #(.N(N)) bus();
    logic         re, we;
    logic [2:0]   ra, wa;
    logic [N-1:0] wd;
    wire  [N-1:0] rd;

    reg_file_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rf_read_enable_o(re), .rf_write_enable_o(we),
        .rf_read_addr_o(ra), .rf_write_addr_o(wa),
        .rf_write_data_o(wd), .rf_read_data_i(rd)
    );

    // Register file: synchronous write, read data driven only in the cycle after a read edge.
    logic [N-1:0] rf_mem [8] = '{default: '0};
    logic         rd_v = 1'b0;
    logic [N-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (we) rf_mem[wa] <= wd;
        rd_v <= re;
        if (re) rd_q <= rf_mem[ra];
    end
    assign rd = rd_v ? rd_q : 'z;

    logic [N-1:0] exp_mem [8] = '{default: '0};
    logic [N-1:0] exp_rsp = '0;
    logic [N-1:0] last_rsp = '0;
    int           exp_lat = 0;
    int           exp_rd [$];
    int           exp_wa [$];
    logic [N-1:0] exp_wd [$];
    bit           busy = 1'b0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        chk("rf_enables_exclusive", {63'd0, re & we}, 64'd0);
        if (!rst_n) begin
            chk("reset_ctrl", {54'd0, bus.cmd_ready, bus.rsp_valid, re, we, ra, wa}, 64'd0);
            chk("reset_data", {bus.rsp_data, wd}, 64'd0);
        end else if (!busy) begin
            chk("idle_outputs", {60'd0, bus.cmd_ready, bus.rsp_valid, re, we}, 64'h8);
        end else begin
            chk("busy_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
            if (re) begin
                if (exp_rd.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
                else chk("read_addr", {61'd0, ra}, 64'(exp_rd.pop_front()));
            end
            if (we) begin
                if (exp_wa.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
                else begin
                    chk("write_addr", {61'd0, wa}, 64'(exp_wa.pop_front()));
                    chk("write_data", {32'd0, wd}, {32'd0, exp_wd.pop_front()});
                end
            end
            if (bus.rsp_valid) begin
                chk("rsp_data", {32'd0, bus.rsp_data}, {32'd0, exp_rsp});
                chk("rsp_quiet", {62'd0, re, we}, 64'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d, input logic [N-1:0] imm);
        logic [N-1:0] a, b;
        @(negedge clk);
        a = exp_mem[s];
        b = exp_mem[d];
        case (op)
            LOAD: begin exp_rsp = imm; exp_lat = 2; exp_wa.push_back(int'(d)); exp_wd.push_back(imm); exp_mem[d] = imm; end
            READ: begin exp_rsp = a; exp_lat = 3; exp_rd.push_back(int'(s)); end
            MOVE: begin
                exp_rsp = a; exp_lat = 4; exp_rd.push_back(int'(s));
                exp_wa.push_back(int'(d)); exp_wd.push_back(a); exp_mem[d] = a;
            end
            default: begin
                exp_rsp = a; exp_lat = 7; exp_rd.push_back(int'(s)); exp_rd.push_back(int'(d));
                exp_wa.push_back(int'(d)); exp_wd.push_back(a);
                exp_wa.push_back(int'(s)); exp_wd.push_back(b);
                exp_mem[d] = a; exp_mem[s] = b;
            end
        endcase
        bus.cmd_op = op; bus.cmd_src = s; bus.cmd_dst = d; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        chk("cmd_ready_before_accept", {63'd0, bus.cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        busy = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'($urandom); bus.cmd_src = 3'($urandom); bus.cmd_dst = 3'($urandom); bus.cmd_imm = $urandom;
    endtask

    task automatic finish_cmd(input int stall);
        int lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        last_rsp = bus.rsp_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("stall_rsp_stable", {32'd0, bus.rsp_data}, {32'd0, last_rsp});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        busy = 1'b0;
        chk("reads_consumed", 64'(exp_rd.size()), 64'd0);
        chk("writes_consumed", 64'(exp_wa.size()), 64'd0);
        for (int i = 0; i < 8; i++) chk("rf_contents", {32'd0, rf_mem[i]}, {32'd0, exp_mem[i]});
    endtask

    task automatic run(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d, input logic [N-1:0] imm, input int stall);
        issue(op, s, d, imm);
        finish_cmd(stall);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src = '0; bus.cmd_dst = '0;
        bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_release", {63'd0, bus.cmd_ready}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run(LOAD, 3'd0, 3'd3, 32'hA5, 0);
        chk("load_rsp_literal", {32'd0, last_rsp}, 64'hA5);
        chk("load_r3_literal", {32'd0, rf_mem[3]}, 64'hA5);
        run(MOVE, 3'd3, 3'd5, 32'h0, 0);
        chk("move_rsp_literal", {32'd0, last_rsp}, 64'hA5);
        run(READ, 3'd5, 3'd0, 32'h0, 0);
        chk("read_r5_literal", {32'd0, last_rsp}, 64'hA5);

        run(LOAD, 3'd0, 3'd1, 32'h11, 0);
        run(LOAD, 3'd0, 3'd2, 32'h22, 0);
        run(SWAP, 3'd1, 3'd2, 32'h0, 0);
        chk("swap_rsp_literal", {32'd0, last_rsp}, 64'h11);
        chk("swap_r1_literal", {32'd0, rf_mem[1]}, 64'h22);
        chk("swap_r2_literal", {32'd0, rf_mem[2]}, 64'h11);

        run(READ, 3'd2, 3'd0, 32'h0, 5);
        chk("stalled_read_literal", {32'd0, last_rsp}, 64'h11);

        run(LOAD, 3'd0, 3'd4, 32'h3C, 0);
        run(SWAP, 3'd4, 3'd4, 32'h0, 0);
        chk("swap_same_literal", {32'd0, last_rsp}, 64'h3C);
        run(MOVE, 3'd4, 3'd4, 32'h0, 2);
        run(LOAD, 3'd0, 3'd7, 32'hFFFF_FFFF, 1);
        run(READ, 3'd7, 3'd0, 32'h0, 0);
        chk("read_max_literal", {32'd0, last_rsp}, 64'hFFFF_FFFF);
        run(SWAP, 3'd7, 3'd0, 32'h0, 0);

        run(LOAD, 3'd0, 3'd1, 32'h11, 0);
        run(LOAD, 3'd0, 3'd2, 32'h22, 0);
        issue(SWAP, 3'd1, 3'd2, 32'h0);
        repeat (6) @(negedge clk);
        chk("in_wr_b", {59'd0, we, re, wa}, {59'd0, 2'b10, 3'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {54'd0, bus.cmd_ready, bus.rsp_valid, re, we, ra, wa}, 64'd0);
        chk("abort_data", {bus.rsp_data, wd}, 64'd0);
        busy = 1'b0;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        exp_mem[1] = 32'h11;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        chk("abort_r1_literal", {32'd0, rf_mem[1]}, 64'h11);
        chk("abort_r2_literal", {32'd0, rf_mem[2]}, 64'h11);
        run(READ, 3'd1, 3'd0, 32'h0, 0);
        chk("post_abort_read", {32'd0, last_rsp}, 64'h11);
        run(SWAP, 3'd3, 3'd6, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
